// File: rtl/reg2_split_pkg.sv
// Shared constants for the two-port steering queue: default sizes and
// the destination-select encodings.
package reg2_split_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;

    localparam logic SEL_PORT1 = 1'b0;
    localparam logic SEL_PORT2 = 1'b1;

endpackage

// File: rtl/reg2_split_fifo.sv
// Single-clock FIFO used once per output port. The head entry is read
// straight out of registered storage, so there is no input-to-output path.
module split_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // A push into a full queue or a pop from an empty one is dropped here,
    // which keeps the count inside 0..DEPTH whatever the caller does.
    assign w_do_push = i_push && (r_count != CNT_MAX);
    assign w_do_pop  = i_pop  && (r_count != {CW{1'b0}});

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == CNT_MAX);
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/reg2_split.sv
// Steers each accepted input word into one of two independent FIFOs;
// a full destination only stalls traffic aimed at that destination.
module reg2_split
    import reg2_split_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out2_valid,
    input  logic                       out2_ready,
    output logic [WIDTH-1:0]           out2_data,
    output logic [$clog2(DEPTH):0]     cnt1,
    output logic [$clog2(DEPTH):0]     cnt2
);

    logic w_full1;
    logic w_full2;
    logic w_empty1;
    logic w_empty2;
    logic w_accept;
    logic w_push1;
    logic w_push2;
    logic w_pop1;
    logic w_pop2;

    // Readiness looks only at the fill level, never at a same-cycle pop.
    assign in_ready = (in_sel == SEL_PORT2) ? !w_full2 : !w_full1;
    assign w_accept = in_valid && in_ready;
    assign w_push1  = w_accept && (in_sel == SEL_PORT1);
    assign w_push2  = w_accept && (in_sel == SEL_PORT2);

    assign out1_valid = !w_empty1;
    assign out2_valid = !w_empty2;
    assign w_pop1     = out1_valid && out1_ready;
    assign w_pop2     = out2_valid && out2_ready;

    split_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_pop   (w_pop1),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_count (cnt1),
        .o_head  (out1_data)
    );

    split_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push2),
        .i_data  (in_data),
        .i_pop   (w_pop2),
        .o_full  (w_full2),
        .o_empty (w_empty2),
        .o_count (cnt2),
        .o_head  (out2_data)
    );

endmodule

// File: tb/tb_reg2_split.sv
// Directed and scoreboarded checks for reg2_split at WIDTH=8, DEPTH=2.
module tb_reg2_split;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
    logic [1:0]       cnt1;
    logic [1:0]       cnt2;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];

    reg2_split #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int cycles;
        logic exp_rdy;
        logic [7:0] d;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        tick(); tick();
        check("rst_cnt1", cnt1, 2'd0);
        check("rst_cnt2", cnt2, 2'd0);
        check("rst_v1", out1_valid, 1'b0);
        check("rst_v2", out2_valid, 1'b0);
        rst_n = 1'b1; #1;
        check("rel_rdy_sel0", in_ready, 1'b1);
        in_sel = 1'b1; #1;
        check("rel_rdy_sel1", in_ready, 1'b1);

        // Basic one-word traffic to each port
        out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b0; #1;
        check("b_rdy", in_ready, 1'b1);
        tick();
        in_data = 8'h22; in_sel = 1'b1;
        check("b_v1", out1_valid, 1'b1);
        check("b_d1", out1_data, 8'h11);
        check("b_cnt1", cnt1, 2'd1);
        tick();
        in_valid = 1'b0;
        check("b_v1_off", out1_valid, 1'b0);
        check("b_cnt1_0", cnt1, 2'd0);
        check("b_v2", out2_valid, 1'b1);
        check("b_d2", out2_data, 8'h22);
        tick();
        check("b_cnt2_0", cnt2, 2'd0);
        check("b_v2_off", out2_valid, 1'b0);

        // Fill port 1; port 2 must still accept
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        check("f_cnt1", cnt1, 2'd2);
        in_data = 8'hC1; #1;
        check("f_rdy_sel0", in_ready, 1'b0);
        in_sel = 1'b1; in_data = 8'hB1; #1;
        check("f_rdy_sel1", in_ready, 1'b1);
        tick();
        check("f_v2", out2_valid, 1'b1);
        check("f_d2", out2_data, 8'hB1);
        check("f_cnt2", cnt2, 2'd1);
        check("f_cnt1_hold", cnt1, 2'd2);

        // Full queue with same-cycle pop: push refused
        in_sel = 1'b0; in_data = 8'hC1; out1_ready = 1'b1; #1;
        check("p_rdy_full", in_ready, 1'b0);
        check("p_head_a1", out1_data, 8'hA1);
        tick();
        check("p_cnt1", cnt1, 2'd1);
        check("p_head_a2", out1_data, 8'hA2);
        out1_ready = 1'b0; #1;
        check("p_rdy_after", in_ready, 1'b1);
        tick();
        check("p_cnt1_2", cnt1, 2'd2);
        in_valid = 1'b0; out1_ready = 1'b1;
        tick();
        check("p_head_c1", out1_data, 8'hC1);
        check("p_cnt1_1", cnt1, 2'd1);

        // Simultaneous push and pop at count 1
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33; #1;
        check("s_rdy", in_ready, 1'b1);
        tick();
        check("s_cnt1", cnt1, 2'd1);
        check("s_head", out1_data, 8'h33);
        in_valid = 1'b0; out2_ready = 1'b1;
        tick();
        check("s_cnt1_0", cnt1, 2'd0);
        check("s_cnt2_0", cnt2, 2'd0);

        // Random stream against a queue model
        accepted = 0;
        cycles = 0;
        while (accepted < 200 && cycles < 3000) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = 8'($urandom);
            out1_ready = 1'($urandom_range(0, 1));
            out2_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = in_sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
            check("r_rdy", in_ready, exp_rdy);
            check("r_v1", out1_valid, q1.size() != 0);
            check("r_v2", out2_valid, q2.size() != 0);
            check("r_cnt1", cnt1, q1.size());
            check("r_cnt2", cnt2, q2.size());
            if (q1.size() != 0 && out1_ready) begin
                d = q1.pop_front();
                check("r_d1", out1_data, d);
            end
            if (q2.size() != 0 && out2_ready) begin
                d = q2.pop_front();
                check("r_d2", out2_data, d);
            end
            if (in_valid && exp_rdy) begin
                if (in_sel) q2.push_back(in_data);
                else        q1.push_back(in_data);
                accepted++;
            end
            tick();
            cycles++;
        end
        check("r_done", accepted, 200);
        in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        while (q1.size() != 0 || q2.size() != 0) begin
            if (q1.size() != 0) begin
                d = q1.pop_front();
                check("r_drain1", out1_data, d);
            end
            if (q2.size() != 0) begin
                d = q2.pop_front();
                check("r_drain2", out2_data, d);
            end
            tick();
        end
        check("r_end_cnt1", cnt1, 2'd0);
        check("r_end_cnt2", cnt2, 2'd0);

        // Reset while holding words
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hD1; tick();
        in_data = 8'hD2; tick();
        in_sel = 1'b1; in_data = 8'hE1; tick();
        check("x_cnt1", cnt1, 2'd2);
        check("x_cnt2", cnt2, 2'd1);
        rst_n = 1'b0; in_data = 8'hF1; tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check("x_cnt1_0", cnt1, 2'd0);
        check("x_cnt2_0", cnt2, 2'd0);
        check("x_v1", out1_valid, 1'b0);
        check("x_v2", out2_valid, 1'b0);
        in_sel = 1'b0; #1;
        check("x_rdy0", in_ready, 1'b1);
        in_sel = 1'b1; #1;
        check("x_rdy1", in_ready, 1'b1);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55; out1_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("x_head", out1_data, 8'h55);
        check("x_cnt1_1", cnt1, 2'd1);
        tick();
        check("x_cnt1_end", cnt1, 2'd0);
        check("x_v2_end", out2_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
